// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU op encoding and
// the ID/EX pipeline register payload.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        alu_op_t           alu_op;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              branch;
        logic              illegal;
    } id_ex_t;

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two async read ports, one sync write port.
// Reg 0 reads as zero; a same-cycle write to a read register is forwarded.
// Ports: clk, rst (async, active-high), rs_addr/rt_addr -> rs_data/rt_data,
//        we/wa/wd write port.
module register_file
    import mips_pkg::*;
#(
    parameter int unsigned REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [XLEN-1:0]   rs_data,
    output logic [XLEN-1:0]   rt_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] regs [REG_COUNT];

    // Storage; reg 0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (we && wa == rs_addr) begin
            rs_data = wd;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (we && wa == rt_addr) begin
            rt_data = wd;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: IF/ID register, field decode, register-file read,
// load-use hazard detection and the registered ID/EX bundle.
// Ports: clk, rst (async, active-high); instr/pc_in from fetch; flush from
//        branch resolution; wb_* write-back port; stall_fetch (combinational)
//        back to fetch; id_* registered ID/EX fields to execute.
module instruction_decode
    import mips_pkg::*;
#(
    parameter int unsigned REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_fetch,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_reg_write,
    output logic        id_branch,
    output logic        id_illegal
);

    logic [XLEN-1:0]   ifid_instr;
    logic [XLEN-1:0]   ifid_pc;
    logic              ifid_valid;
    logic [XLEN-1:0]   rf_rs_data;
    logic [XLEN-1:0]   rf_rt_data;
    logic [REG_AW-1:0] dest;
    logic              uses_rt;
    logic              hazard;
    id_ex_t            dec;
    id_ex_t            id_ex_q;

    // IF/ID register: flush squashes, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!stall_fetch) begin
            ifid_instr <= instr;
            ifid_pc    <= pc_in;
            ifid_valid <= 1'b1;
        end
    end

    register_file #(.REG_COUNT(REG_COUNT)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (ifid_instr[25:21]),
        .rt_addr (ifid_instr[20:16]),
        .rs_data (rf_rs_data),
        .rt_data (rf_rt_data),
        .we      (wb_reg_write),
        .wa      (wb_rd),
        .wd      (wb_data)
    );

    // Field and control decode of the IF/ID instruction
    always_comb begin
        dec         = '0;
        uses_rt     = 1'b0;
        dest        = ifid_instr[20:16];
        dec.valid   = ifid_valid;
        dec.pc      = ifid_pc;
        dec.rs      = ifid_instr[25:21];
        dec.rt      = ifid_instr[20:16];
        dec.rs_data = rf_rs_data;
        dec.rt_data = rf_rt_data;
        dec.imm     = sign_ext16(ifid_instr[15:0]);
        case (ifid_instr[31:26])
            OP_RTYPE: begin
                uses_rt = 1'b1;
                dest    = ifid_instr[15:11];
                dec.reg_write = 1'b1;
                case (ifid_instr[5:0])
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: begin
                        dec.reg_write = 1'b0;
                        dec.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                uses_rt    = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.rd = dest;
        if (dest == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    // Load in ID/EX whose destination feeds the instruction in IF/ID
    assign hazard = ifid_valid & id_ex_q.valid & id_ex_q.mem_read
                  & (id_ex_q.rd != '0)
                  & ((id_ex_q.rd == dec.rs) | (uses_rt & (id_ex_q.rd == dec.rt)));

    assign stall_fetch = hazard & ~flush;

    // ID/EX register; an empty IF/ID slot also produces an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else if (flush || hazard || !ifid_valid) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= dec;
        end
    end

    assign id_valid     = id_ex_q.valid;
    assign id_pc        = id_ex_q.pc;
    assign id_rs_data   = id_ex_q.rs_data;
    assign id_rt_data   = id_ex_q.rt_data;
    assign id_imm       = id_ex_q.imm;
    assign id_rs        = id_ex_q.rs;
    assign id_rt        = id_ex_q.rt;
    assign id_rd        = id_ex_q.rd;
    assign id_alu_op    = id_ex_q.alu_op;
    assign id_alu_src   = id_ex_q.alu_src;
    assign id_mem_read  = id_ex_q.mem_read;
    assign id_mem_write = id_ex_q.mem_write;
    assign id_reg_write = id_ex_q.reg_write;
    assign id_branch    = id_ex_q.branch;
    assign id_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;

    localparam logic [31:0] NOP_I   = 32'h0000_0020; // add $0,$0,$0
    localparam logic [31:0] ADD3    = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] ADD5    = 32'h0084_2820; // add $5,$4,$4
    localparam logic [31:0] ADD5_00 = 32'h0000_2820; // add $5,$0,$0
    localparam logic [31:0] ADD0    = 32'h0022_0020; // add $0,$1,$2
    localparam logic [31:0] SUB7    = 32'h0022_3822;
    localparam logic [31:0] AND7    = 32'h0022_3824;
    localparam logic [31:0] OR7     = 32'h0022_3825;
    localparam logic [31:0] SLT7    = 32'h0022_382A;
    localparam logic [31:0] LW4     = 32'h8C04_0008; // lw $4,8($0)
    localparam logic [31:0] LW0     = 32'h8C00_0000; // lw $0,0($0)
    localparam logic [31:0] SW1     = 32'hAC41_0004; // sw $1,4($2)
    localparam logic [31:0] SW4     = 32'hAC04_0000; // sw $4,0($0)
    localparam logic [31:0] BEQ12   = 32'h1022_0003; // beq $1,$2,3
    localparam logic [31:0] BEQ04   = 32'h1004_0000; // beq $0,$4,0
    localparam logic [31:0] ADDI6   = 32'h2006_FFFF; // addi $6,$0,-1
    localparam logic [31:0] ADDI4   = 32'h2004_0001; // addi $4,$0,1
    localparam logic [31:0] ILL3F   = 32'hFC00_0000;
    localparam logic [31:0] SLL0    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_fetch;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [2:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        id_branch;
    logic        id_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_decode #(.REG_COUNT(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .pc_in        (pc_in),
        .flush        (flush),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_fetch  (stall_fetch),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_alu_op    (id_alu_op),
        .id_alu_src   (id_alu_src),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_reg_write (id_reg_write),
        .id_branch    (id_branch),
        .id_illegal   (id_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        instr = NOP_I; pc_in = '0;
        repeat (2) step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        checks++; if ({id_alu_op, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_illegal} !== 9'h0)
            begin errors++; $display("FAIL reset_ctrl got=%h exp=0", {id_alu_op, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_illegal}); end
        checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall_fetch); end
        checks++; if (dut.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid got=%0h exp=0", dut.ifid_valid); end
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        instr = ADD3; pc_in = 32'h0;
        step();
        instr = NOP_I; pc_in = 32'h4;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL add_early got=%0h exp=0", id_valid); end
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0h exp=1", id_valid); end
        checks++; if (id_alu_op !== 3'd0) begin errors++; $display("FAIL add_alu got=%0d exp=0", id_alu_op); end
        checks++; if (id_rd !== 5'd3) begin errors++; $display("FAIL add_rd got=%0d exp=3", id_rd); end
        checks++; if (id_reg_write !== 1'b1) begin errors++; $display("FAIL add_regwrite got=%0h exp=1", id_reg_write); end
        checks++; if ({id_rs, id_rt} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_rs_rt got=%0d/%0d exp=1/2", id_rs, id_rt); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL add_pc got=%h exp=0", id_pc); end
        checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got=%0h exp=0", id_illegal); end
    endtask

    task automatic test_bypass();
        instr = ADD3; pc_in = 32'h8;
        step();
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_00AA;
        instr = ADDI6; pc_in = 32'hC;
        step();
        checks++; if (id_rs_data !== 32'h0000_00AA) begin errors++; $display("FAIL bypass_rs got=%h exp=000000aa", id_rs_data); end
        checks++; if (id_rt_data !== 32'h0) begin errors++; $display("FAIL bypass_rt got=%h exp=0", id_rt_data); end
        wb_rd = 5'd0; wb_data = 32'h0000_0055;
        instr = SUB7; pc_in = 32'h10;
        step();
        checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL r0_same_cycle got=%h exp=0", id_rs_data); end
        wb_reg_write = 1'b0;
        instr = ADDI6; pc_in = 32'h14;
        step();
        checks++; if (id_rs_data !== 32'h0000_00AA) begin errors++; $display("FAIL reg1_stored got=%h exp=000000aa", id_rs_data); end
        instr = NOP_I; pc_in = 32'h18;
        step();
        checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL r0_after_write got=%h exp=0", id_rs_data); end
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [5];
        logic [2:0]  exp_alu [5];
        logic        exp_rw [5];
        logic [4:0]  exp_rd [5];
        prog = '{SUB7, AND7, OR7, SLT7, ADD0};
        exp_alu = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        exp_rw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rd = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd0};
        for (int i = 0; i < 6; i++) begin
            instr = (i < 5) ? prog[i] : NOP_I;
            pc_in = 32'h100 + 32'(i * 4);
            step();
            if (i > 0) begin
                checks++; if (id_alu_op !== exp_alu[i-1]) begin errors++; $display("FAIL alu_op[%0d] got=%0d exp=%0d", i-1, id_alu_op, exp_alu[i-1]); end
                checks++; if (id_reg_write !== exp_rw[i-1]) begin errors++; $display("FAIL alu_rw[%0d] got=%0h exp=%0h", i-1, id_reg_write, exp_rw[i-1]); end
                checks++; if (id_rd !== exp_rd[i-1]) begin errors++; $display("FAIL alu_rd[%0d] got=%0d exp=%0d", i-1, id_rd, exp_rd[i-1]); end
                checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d] got=%0h exp=1", i-1, id_valid); end
            end
        end
    endtask

    task automatic test_itypes();
        logic [31:0] prog [5];
        logic [2:0]  exp_alu [5];
        logic [4:0]  exp_ctl [5];   // {alu_src, mem_write, branch, reg_write, illegal}
        logic [31:0] exp_imm [5];
        prog = '{SW1, BEQ12, ADDI6, ILL3F, SLL0};
        exp_alu = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        exp_ctl = '{5'b11000, 5'b00100, 5'b10010, 5'b00001, 5'b00001};
        exp_imm = '{32'h4, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            instr = (i < 5) ? prog[i] : NOP_I;
            pc_in = 32'h200 + 32'(i * 4);
            step();
            if (i > 0) begin
                checks++; if (id_alu_op !== exp_alu[i-1]) begin errors++; $display("FAIL it_alu[%0d] got=%0d exp=%0d", i-1, id_alu_op, exp_alu[i-1]); end
                checks++; if ({id_alu_src, id_mem_write, id_branch, id_reg_write, id_illegal} !== exp_ctl[i-1])
                    begin errors++; $display("FAIL it_ctl[%0d] got=%b exp=%b", i-1, {id_alu_src, id_mem_write, id_branch, id_reg_write, id_illegal}, exp_ctl[i-1]); end
                checks++; if (id_imm !== exp_imm[i-1]) begin errors++; $display("FAIL it_imm[%0d] got=%h exp=%h", i-1, id_imm, exp_imm[i-1]); end
                checks++; if ({id_valid, id_mem_read} !== 2'b10) begin errors++; $display("FAIL it_valid_mr[%0d] got=%b exp=10", i-1, {id_valid, id_mem_read}); end
            end
        end
    endtask

    task automatic test_load_use();
        instr = LW4; pc_in = 32'h40;
        step();
        checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL lu_pre_stall got=%0h exp=0", stall_fetch); end
        instr = ADD5; pc_in = 32'h44;
        step();
        checks++; if ({id_mem_read, id_rd, id_reg_write} !== {1'b1, 5'd4, 1'b1}) begin errors++; $display("FAIL lu_lw got=%b exp=1001001", {id_mem_read, id_rd, id_reg_write}); end
        checks++; if (stall_fetch !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0h exp=1", stall_fetch); end
        step();
        checks++; if ({id_valid, id_mem_read, id_reg_write, id_rd, id_rs, id_pc} !== '0) begin errors++; $display("FAIL lu_bubble got=%b/%0d/%0d/%h exp=0", {id_valid, id_mem_read, id_reg_write}, id_rd, id_rs, id_pc); end
        checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL lu_stall_one got=%0h exp=0", stall_fetch); end
        instr = NOP_I; pc_in = 32'h48;
        step();
        checks++; if ({id_valid, id_rs, id_rd} !== {1'b1, 5'd4, 5'd5}) begin errors++; $display("FAIL lu_issue got=%0h/%0d/%0d exp=1/4/5", id_valid, id_rs, id_rd); end
        checks++; if (id_pc !== 32'h44) begin errors++; $display("FAIL lu_issue_pc got=%h exp=44", id_pc); end
        step();
    endtask

    task automatic test_flush_hazard();
        instr = LW4; pc_in = 32'h80;
        step();
        instr = ADD5; pc_in = 32'h84;
        step();
        checks++; if (stall_fetch !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got=%0h exp=1", stall_fetch); end
        flush = 1'b1;
        #1;
        checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL fl_stall got=%0h exp=0", stall_fetch); end
        step();
        checks++; if ({id_valid, id_mem_read} !== 2'b00) begin errors++; $display("FAIL fl_idex got=%b exp=00", {id_valid, id_mem_read}); end
        checks++; if (dut.ifid_valid !== 1'b0) begin errors++; $display("FAIL fl_ifid got=%0h exp=0", dut.ifid_valid); end
        flush = 1'b0; instr = NOP_I; pc_in = 32'h88;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_squashed got=%0h exp=0", id_valid); end
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fl_resume got=%0h exp=1", id_valid); end
    endtask

    task automatic test_hazard_cases();
        logic [31:0] lds [4];
        logic [31:0] fol [4];
        logic        exp_st [4];
        lds = '{LW4, LW4, LW0, LW4};
        fol = '{ADDI4, SW4, ADD5_00, BEQ04};
        exp_st = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            instr = lds[i]; pc_in = 32'h300;
            step();
            instr = fol[i]; pc_in = 32'h304;
            step();
            checks++; if (stall_fetch !== exp_st[i]) begin errors++; $display("FAIL hz_case[%0d] got=%0h exp=%0h", i, stall_fetch, exp_st[i]); end
            instr = NOP_I; pc_in = 32'h308;
            step();
            step();
        end
    endtask

    task automatic test_reset_mid_stall();
        instr = LW4; pc_in = 32'h400;
        step();
        instr = ADD5; pc_in = 32'h404;
        step();
        checks++; if (stall_fetch !== 1'b1) begin errors++; $display("FAIL rs_pre_stall got=%0h exp=1", stall_fetch); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL rs_stall got=%0h exp=0", stall_fetch); end
        checks++; if ({id_valid, id_mem_read, dut.ifid_valid} !== 3'b000) begin errors++; $display("FAIL rs_state got=%b exp=000", {id_valid, id_mem_read, dut.ifid_valid}); end
        step();
        rst = 1'b0;
        instr = ADD3; pc_in = 32'h500;
        step();
        instr = NOP_I; pc_in = 32'h504;
        step();
        checks++; if ({id_valid, id_rs_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rs_regs_cleared got=%0h/%h exp=1/0", id_valid, id_rs_data); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_bypass();
        test_alu_ops();
        test_itypes();
        test_load_use();
        test_flush_hazard();
        test_hazard_cases();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
